// File: rtl/dc_remover.sv
// dc_remover: turns offset-binary ADC samples into zero-centred signed samples by
// subtracting a per-window (max+min)/2 DC estimate. Define DC_IIR_EN to smooth that estimate.
module dc_remover #(
    parameter int DATA_WIDTH = 12,
    parameter int WIN_LOG2   = 10,
    parameter int IIR_SHIFT  = 2
) (
    input  logic                  adc_clk,
    input  logic                  rst,
    input  logic                  sample_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic [DATA_WIDTH-1:0] dc_level,
    output logic [DATA_WIDTH-1:0] amplitude,
    output logic                  dc_ready
);

    typedef enum logic [0:0] {
        ST_ACQ   = 1'b0,
        ST_TRACK = 1'b1
    } state_e;

    localparam logic [WIN_LOG2-1:0]   CNT_LAST = {WIN_LOG2{1'b1}};
    localparam logic [WIN_LOG2-1:0]   CNT_ZERO = {WIN_LOG2{1'b0}};
    localparam logic [WIN_LOG2-1:0]   CNT_ONE  = {{(WIN_LOG2-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] ALL_ZERO = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] SAT_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // An out-of-range smoothing shift would silently turn the IIR into a hold.
    if (IIR_SHIFT < 0 || IIR_SHIFT > DATA_WIDTH) begin : g_bad_iir_shift
        $error("dc_remover: IIR_SHIFT out of range");
    end

    state_e                  state_q,      state_d;
    logic [WIN_LOG2-1:0]     cnt_q,        cnt_d;
    logic [DATA_WIDTH-1:0]   run_max_q,    run_max_d;
    logic [DATA_WIDTH-1:0]   run_min_q,    run_min_d;
    logic [DATA_WIDTH-1:0]   dc_level_q,   dc_level_d;
    logic [DATA_WIDTH-1:0]   amplitude_q,  amplitude_d;
    logic                    dc_ready_q,   dc_ready_d;
    logic [DATA_WIDTH-1:0]   data_out_q,   data_out_d;
    logic                    data_valid_q, data_valid_d;

    logic                    terminal_s;
    logic [DATA_WIDTH-1:0]   win_max_s;
    logic [DATA_WIDTH-1:0]   win_min_s;
    logic [DATA_WIDTH:0]     win_sum_s;
    logic [DATA_WIDTH-1:0]   new_dc_s;
    logic [DATA_WIDTH-1:0]   dc_upd_s;
    logic signed [DATA_WIDTH:0] diff_s;
    logic [DATA_WIDTH-1:0]   diff_sat_s;

    // Saturate a DATA_WIDTH+1 signed difference into the DATA_WIDTH signed range.
    function automatic logic [DATA_WIDTH-1:0] sat_diff(input logic signed [DATA_WIDTH:0] d);
        logic [DATA_WIDTH-1:0] r;
        if (d[DATA_WIDTH] != d[DATA_WIDTH-1]) begin
            r = d[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
        end else begin
            r = d[DATA_WIDTH-1:0];
        end
        return r;
    endfunction

    // Window statistics including the current sample, and the datapath values derived from them.
    always_comb begin
        terminal_s = sample_en && (cnt_q == CNT_LAST);
        win_max_s  = (data_in > run_max_q) ? data_in : run_max_q;
        win_min_s  = (data_in < run_min_q) ? data_in : run_min_q;
        win_sum_s  = {1'b0, win_max_s} + {1'b0, win_min_s};
        new_dc_s   = win_sum_s[DATA_WIDTH:1];
        diff_s     = $signed({1'b0, data_in}) - $signed({1'b0, dc_level_q});
        diff_sat_s = sat_diff(diff_s);
    end

`ifdef DC_IIR_EN
    logic signed [DATA_WIDTH:0] iir_err_s;
    logic signed [DATA_WIDTH:0] iir_step_s;
    logic signed [DATA_WIDTH:0] iir_sum_s;

    // First window seeds the estimate; later windows move a 2^-IIR_SHIFT fraction toward the new value.
    always_comb begin
        iir_err_s  = $signed({1'b0, new_dc_s}) - $signed({1'b0, dc_level_q});
        iir_step_s = iir_err_s >>> IIR_SHIFT;
        iir_sum_s  = $signed({1'b0, dc_level_q}) + iir_step_s;
        if (dc_ready_q) begin
            dc_upd_s = iir_sum_s[DATA_WIDTH-1:0];
        end else begin
            dc_upd_s = new_dc_s;
        end
    end
`else
    // Without smoothing every completed window replaces the estimate outright.
    always_comb begin
        dc_upd_s = new_dc_s;
    end
`endif

    // Next-state logic for the window tracker, DC estimate and output path.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        run_max_d    = run_max_q;
        run_min_d    = run_min_q;
        dc_level_d   = dc_level_q;
        amplitude_d  = amplitude_q;
        dc_ready_d   = dc_ready_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;

        if (sample_en) begin
            if (terminal_s) begin
                cnt_d       = CNT_ZERO;
                run_max_d   = ALL_ZERO;
                run_min_d   = ALL_ONES;
                amplitude_d = win_max_s - win_min_s;
                dc_level_d  = dc_upd_s;
            end else begin
                cnt_d     = cnt_q + CNT_ONE;
                run_max_d = win_max_s;
                run_min_d = win_min_s;
            end

            // The output uses dc_level_q, so the terminal sample still sees the old estimate.
            case (state_q)
                ST_ACQ: begin
                    if (terminal_s) begin
                        state_d    = ST_TRACK;
                        dc_ready_d = 1'b1;
                    end else begin
                        state_d = ST_ACQ;
                    end
                end
                ST_TRACK: begin
                    data_out_d   = diff_sat_s;
                    data_valid_d = 1'b1;
                end
                default: begin
                    state_d    = ST_ACQ;
                    dc_ready_d = 1'b0;
                end
            endcase
        end else begin
            data_valid_d = 1'b0;
        end
    end

    // State and output registers; reset discards any partial window.
    always_ff @(posedge adc_clk) begin
        if (rst) begin
            state_q      <= ST_ACQ;
            cnt_q        <= CNT_ZERO;
            run_max_q    <= ALL_ZERO;
            run_min_q    <= ALL_ONES;
            dc_level_q   <= ALL_ZERO;
            amplitude_q  <= ALL_ZERO;
            dc_ready_q   <= 1'b0;
            data_out_q   <= ALL_ZERO;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            run_max_q    <= run_max_d;
            run_min_q    <= run_min_d;
            dc_level_q   <= dc_level_d;
            amplitude_q  <= amplitude_d;
            dc_ready_q   <= dc_ready_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign dc_level   = dc_level_q;
    assign amplitude  = amplitude_q;
    assign dc_ready   = dc_ready_q;

endmodule

// File: tb/tb_dc_remover.sv
// Directed self-checking bench for dc_remover with a 16-sample window.
// Covers reset, flat input, alternating input, saturation, sparse strobes, mid-window reset and window sequencing.
module tb_dc_remover;

    logic        clk;
    logic        rst;
    logic        sample_en;
    logic [11:0] data_in;
    logic [11:0] data_out;
    logic        data_valid;
    logic [11:0] dc_level;
    logic [11:0] amplitude;
    logic        dc_ready;

    int checks;
    int errors;

    dc_remover #(
        .DATA_WIDTH(12),
        .WIN_LOG2  (4),
        .IIR_SHIFT (2)
    ) dut (
        .adc_clk   (clk),
        .rst       (rst),
        .sample_en (sample_en),
        .data_in   (data_in),
        .data_out  (data_out),
        .data_valid(data_valid),
        .dc_level  (dc_level),
        .amplitude (amplitude),
        .dc_ready  (dc_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst       = 1'b1;
        sample_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send(input logic [11:0] d);
        sample_en = 1'b1;
        data_in   = d;
        @(posedge clk);
        #1;
        sample_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_alt(input logic [11:0] lo, input logic [11:0] hi);
        for (int i = 0; i < 16; i++) send((i % 2 == 0) ? lo : hi);
    endtask

    task automatic test_reset();
        send(12'd3000);
        do_reset();
        checks += 5;
        if (data_out !== 12'd0)   begin errors++; $display("FAIL reset_data_out got %0d want 0", data_out); end
        if (data_valid !== 1'b0)  begin errors++; $display("FAIL reset_data_valid got %b want 0", data_valid); end
        if (dc_level !== 12'd0)   begin errors++; $display("FAIL reset_dc_level got %0d want 0", dc_level); end
        if (amplitude !== 12'd0)  begin errors++; $display("FAIL reset_amplitude got %0d want 0", amplitude); end
        if (dc_ready !== 1'b0)    begin errors++; $display("FAIL reset_dc_ready got %b want 0", dc_ready); end
    endtask

    task automatic test_constant();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            send(12'd2048);
            checks++;
            if (data_valid !== 1'b0) begin errors++; $display("FAIL const_acq_valid idx %0d got %b want 0", i, data_valid); end
        end
        checks += 3;
        if (dc_ready !== 1'b1)     begin errors++; $display("FAIL const_dc_ready got %b want 1", dc_ready); end
        if (dc_level !== 12'd2048) begin errors++; $display("FAIL const_dc_level got %0d want 2048", dc_level); end
        if (amplitude !== 12'd0)   begin errors++; $display("FAIL const_amplitude got %0d want 0", amplitude); end
        send(12'd2048);
        checks += 2;
        if (data_valid !== 1'b1) begin errors++; $display("FAIL const_out_valid got %b want 1", data_valid); end
        if (data_out !== 12'd0)  begin errors++; $display("FAIL const_out got %0d want 0", data_out); end
        idle(1);
        checks++;
        if (data_valid !== 1'b0) begin errors++; $display("FAIL const_valid_drop got %b want 0", data_valid); end
    endtask

    task automatic test_alternating();
        logic [11:0] exp_v;
        logic [11:0] d;
        do_reset();
        send_alt(12'd1000, 12'd3000);
        checks += 2;
        if (dc_level !== 12'd2000)  begin errors++; $display("FAIL alt_dc_level got %0d want 2000", dc_level); end
        if (amplitude !== 12'd2000) begin errors++; $display("FAIL alt_amplitude got %0d want 2000", amplitude); end
        for (int i = 0; i < 16; i++) begin
            d     = (i % 2 == 0) ? 12'd1000 : 12'd3000;
            exp_v = (i % 2 == 0) ? 12'hC18 : 12'h3E8;
            send(d);
            checks += 2;
            if (data_valid !== 1'b1) begin errors++; $display("FAIL alt_valid idx %0d got %b want 1", i, data_valid); end
            if (data_out !== exp_v)  begin errors++; $display("FAIL alt_out idx %0d got %h want %h", i, data_out, exp_v); end
        end
        idle(1);
        checks += 2;
        if (data_valid !== 1'b0)   begin errors++; $display("FAIL alt_idle_valid got %b want 0", data_valid); end
        if (data_out !== 12'h3E8)  begin errors++; $display("FAIL alt_hold got %h want 3e8", data_out); end
    endtask

    task automatic test_saturation();
        do_reset();
        send_alt(12'd0, 12'd200);
        checks += 2;
        if (dc_level !== 12'd100)  begin errors++; $display("FAIL sat1_dc_level got %0d want 100", dc_level); end
        if (amplitude !== 12'd200) begin errors++; $display("FAIL sat1_amplitude got %0d want 200", amplitude); end
        send(12'd4095);
        checks++;
        if (data_out !== 12'h7FF) begin errors++; $display("FAIL sat_pos got %h want 7ff", data_out); end
        do_reset();
        for (int i = 0; i < 16; i++) send(12'd4000);
        checks++;
        if (dc_level !== 12'd4000) begin errors++; $display("FAIL sat2_dc_level got %0d want 4000", dc_level); end
        send(12'd0);
        checks++;
        if (data_out !== 12'h800) begin errors++; $display("FAIL sat_neg got %h want 800", data_out); end
    endtask

    task automatic test_sparse();
        logic exp_rdy;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            send((i % 2 == 0) ? 12'd1000 : 12'd3000);
            exp_rdy = (i == 15);
            checks += 2;
            if (data_valid !== 1'b0)   begin errors++; $display("FAIL sparse_acq_valid idx %0d got %b want 0", i, data_valid); end
            if (dc_ready !== exp_rdy)  begin errors++; $display("FAIL sparse_ready idx %0d got %b want %b", i, dc_ready, exp_rdy); end
            idle(2);
        end
        checks += 2;
        if (dc_level !== 12'd2000)  begin errors++; $display("FAIL sparse_dc_level got %0d want 2000", dc_level); end
        if (amplitude !== 12'd2000) begin errors++; $display("FAIL sparse_amplitude got %0d want 2000", amplitude); end
        for (int i = 0; i < 4; i++) begin
            send(12'd3000);
            checks += 2;
            if (data_valid !== 1'b1)  begin errors++; $display("FAIL sparse_track_valid idx %0d got %b want 1", i, data_valid); end
            if (data_out !== 12'h3E8) begin errors++; $display("FAIL sparse_track_out idx %0d got %h want 3e8", i, data_out); end
            for (int k = 0; k < 2; k++) begin
                idle(1);
                checks++;
                if (data_valid !== 1'b0) begin errors++; $display("FAIL sparse_gap_valid idx %0d got %b want 0", i, data_valid); end
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        send_alt(12'd1000, 12'd3000);
        for (int i = 0; i < 5; i++) send((i % 2 == 0) ? 12'd1000 : 12'd3000);
        rst       = 1'b1;
        sample_en = 1'b1;
        data_in   = 12'd3000;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        sample_en = 1'b0;
        checks += 5;
        if (data_out !== 12'd0)  begin errors++; $display("FAIL midrst_data_out got %0d want 0", data_out); end
        if (data_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", data_valid); end
        if (dc_level !== 12'd0)  begin errors++; $display("FAIL midrst_dc_level got %0d want 0", dc_level); end
        if (amplitude !== 12'd0) begin errors++; $display("FAIL midrst_amplitude got %0d want 0", amplitude); end
        if (dc_ready !== 1'b0)   begin errors++; $display("FAIL midrst_ready got %b want 0", dc_ready); end
        for (int i = 0; i < 16; i++) begin
            send((i % 2 == 0) ? 12'd1500 : 12'd2500);
            checks++;
            if (data_valid !== 1'b0) begin errors++; $display("FAIL midrst_acq_valid idx %0d got %b want 0", i, data_valid); end
        end
        checks += 2;
        if (dc_level !== 12'd2000)  begin errors++; $display("FAIL midrst_dc_level2 got %0d want 2000", dc_level); end
        if (amplitude !== 12'd1000) begin errors++; $display("FAIL midrst_amplitude2 got %0d want 1000", amplitude); end
        send(12'd2500);
        checks += 2;
        if (data_valid !== 1'b1)  begin errors++; $display("FAIL midrst_out_valid got %b want 1", data_valid); end
        if (data_out !== 12'd500) begin errors++; $display("FAIL midrst_out got %0d want 500", data_out); end
    endtask

    task automatic test_window_sequence();
        logic [11:0] exp_dc2;
        logic [11:0] exp_dc3;
        logic [11:0] exp_first3;
`ifdef DC_IIR_EN
        exp_dc2    = 12'd2100;
        exp_dc3    = 12'd1975;
        exp_first3 = 12'hA24;   // 600 - 2100 = -1500
`else
        exp_dc2    = 12'd2400;
        exp_dc3    = 12'd1600;
        exp_first3 = 12'h8F8;   // 600 - 2400 = -1800
`endif
        do_reset();
        send_alt(12'd1000, 12'd3000);
        checks++;
        if (dc_level !== 12'd2000) begin errors++; $display("FAIL seq_dc1 got %0d want 2000", dc_level); end
        for (int i = 0; i < 15; i++) send((i % 2 == 0) ? 12'd1400 : 12'd3400);
        send(12'd3400);
        checks += 3;
        // Terminal sample of window 2 is still referenced to the window-1 estimate: 3400 - 2000.
        if (data_out !== 12'd1400)  begin errors++; $display("FAIL seq_terminal_out got %0d want 1400", data_out); end
        if (dc_level !== exp_dc2)   begin errors++; $display("FAIL seq_dc2 got %0d want %0d", dc_level, exp_dc2); end
        if (amplitude !== 12'd2000) begin errors++; $display("FAIL seq_amp2 got %0d want 2000", amplitude); end
        send(12'd600);
        checks++;
        if (data_out !== exp_first3) begin errors++; $display("FAIL seq_first3_out got %h want %h", data_out, exp_first3); end
        for (int i = 1; i < 16; i++) send((i % 2 == 0) ? 12'd600 : 12'd2600);
        checks += 2;
        if (dc_level !== exp_dc3)   begin errors++; $display("FAIL seq_dc3 got %0d want %0d", dc_level, exp_dc3); end
        if (amplitude !== 12'd2000) begin errors++; $display("FAIL seq_amp3 got %0d want 2000", amplitude); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        sample_en = 1'b0;
        data_in   = 12'd0;
        idle(2);
        test_reset();
        test_constant();
        test_alternating();
        test_saturation();
        test_sparse();
        test_mid_reset();
        test_window_sequence();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dc_remover.md
Name: dc_remover

Overview:
- Front-end stage that converts raw offset-binary ADC samples into zero-centred signed samples.
- Sits directly upstream of the zero-crossing frequency detector, which expects DC-free signed data.
- Estimates DC as the midpoint of per-window max/min, subtracts it with saturation, and reports the DC level and peak-to-peak amplitude.

Parameters:
- DATA_WIDTH, 12, sample width for input, output, dc_level and amplitude.
- WIN_LOG2, 10, log2 of the window length in accepted samples (window = 2^WIN_LOG2).
- IIR_SHIFT, 2, smoothing shift, used only when DC_IIR_EN is defined.

Ports:
- adc_clk  in  1  sample clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- sample_en  in  1  strobe: data_in is valid this cycle.
- data_in  in  DATA_WIDTH  unsigned offset-binary ADC sample.
- data_out  out  DATA_WIDTH  signed DC-removed sample.
- data_valid  out  1  one-cycle pulse qualifying data_out.
- dc_level  out  DATA_WIDTH  current unsigned DC estimate.
- amplitude  out  DATA_WIDTH  peak-to-peak (max-min) of the last completed window.
- dc_ready  out  1  high once the first window has completed; stays high until reset.

Behaviour:
- Reset (rst=1 at a clock edge): data_out=0, data_valid=0, dc_level=0, amplitude=0, dc_ready=0.
  - Window counter=0, run_max=0, run_min=all-ones, state=ACQ.
- A reset asserted mid-window discards all partial state; a full new window is required before any output.
- Only cycles with sample_en=1 are processed; on other cycles all state holds and data_valid=0.
- Window tracking on each accepted sample:
  - run_max/run_min update with data_in.
  - The counter increments modulo 2^WIN_LOG2.
- Terminal sample (counter = 2^WIN_LOG2-1), in the same edge:
  - The window's max/min include the terminal sample.
  - Sum is computed at DATA_WIDTH+1 bits; new_dc = (max+min)>>1, truncated.
  - amplitude <= max-min.
  - dc_level <= new_dc.
  - run_max <= 0, run_min <= all-ones.
  - Counter wraps to 0.
- States:
  - ACQ: data_valid stays 0 and data_out stays 0. On the terminal sample, go to TRACK and set dc_ready=1 (visible the next cycle).
  - TRACK: every accepted sample produces an output.
- Output path in TRACK (latency 1 cycle):
  - diff = data_in - dc_level, computed signed at DATA_WIDTH+1 bits using the dc_level held before this edge. The terminal sample therefore uses the old DC; the next sample uses the new DC.
  - Saturate diff to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - data_out <= saturated diff; data_valid <= 1 for that one cycle.
- data_out holds its last value while data_valid=0.
- Flat input (max==min): amplitude=0, dc_level=that value.
- Back-to-back strobes on every cycle are fully supported; there is no backpressure.

Optional Feature:
- Macro: DC_IIR_EN.
- Defined:
  - The first window loads new_dc directly.
  - Each later window: dc_level <= dc_level + ((new_dc - dc_level) >>> IIR_SHIFT), with a signed DATA_WIDTH+1 difference and arithmetic shift.
- Undefined: dc_level <= new_dc at every window end. IIR_SHIFT is unused.
- amplitude is unaffected in both cases.

Test Plan:
- Bench uses WIN_LOG2=4 (16-sample window) unless stated.
- Constant 2048, 16 strobes: data_valid=0 throughout; then dc_ready=1, dc_level=2048, amplitude=0. The next 2048 sample gives data_out=0 one cycle later.
- Alternating 1000/3000, 32 strobes: after window 1, dc_level=2000 and amplitude=2000. Window-2 outputs alternate -1000/+1000, with data_valid one cycle after each strobe.
- Saturation, case 1: window of 0/200 gives dc_level=100; input 4095 then gives data_out=2047.
- Saturation, case 2: window of 4000 gives dc_level=4000; input 0 then gives data_out=-2048.
- Strobe every 3rd cycle with the alternating pattern: same dc_level and amplitude as full rate. Window completes only after 16 strobes (48 cycles). data_valid never asserts without a preceding strobe.
- rst=1 for one cycle at sample 5 of window 2: next cycle all outputs 0 and dc_ready=0. No data_valid until 16 new strobes have been accepted.
- DC_IIR_EN, IIR_SHIFT=2: window 1 raw dc 2000 gives dc_level=2000. Window 2 raw 2400 gives dc_level=2100. Window 3 raw 1600 gives dc_level=1975 (2100 + (-500>>>2)).
